fighter_motion: RTL and testbench



---
 rtl/fighter_motion.sv | 185 ++++++++++++++++++
 tb/tb_fighter_motion.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fighter_motion.sv
// Per-fighter motion controller: walk/clamp, parabolic jump, squat, guard and
// timed knockback. State advances only on frame ticks.
module fighter_motion #(
  parameter int XW       = 11,
  parameter int YW       = 10,
  parameter int MIN_X    = 40,
  parameter int MAX_X    = 600,
  parameter int START_X  = 560,
  parameter bit FACE_INIT = 1'b0,
  parameter int GROUND_Y = -200,
  parameter int SQUAT_Y  = -230,
  parameter int STEP_X   = 4,
  parameter int V0       = 20,
  parameter int G        = 4,
  parameter int MAX_J    = 10,
  parameter int KB_STEP  = 8,
  parameter int KB_LEN   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 right,
  input  logic                 left,
  input  logic                 jump,
  input  logic                 squat,
  input  logic                 defend,
  input  logic                 hit,
  input  logic                 hit_dir,
  output logic signed [XW-1:0] x,
  output logic signed [YW-1:0] y,
  output logic                 facing,
  output logic                 isJ,
  output logic                 isQ,
  output logic                 isD,
  output logic                 isK,
  output logic                 blocked
);

  localparam int JW  = (MAX_J < 1) ? 1 : $clog2(MAX_J + 1);
  localparam int KW  = (KB_LEN < 1) ? 1 : $clog2(KB_LEN + 1);
  localparam int CW  = YW + 8;
  localparam int XCW = XW + 2;

  localparam logic signed [CW-1:0]  V0_C     = CW'(V0);
  localparam logic signed [CW-1:0]  G_C      = CW'(G);
  localparam logic signed [CW-1:0]  TWO_C    = CW'(2);
  localparam logic signed [YW-1:0]  GROUND_C = YW'(GROUND_Y);
  localparam logic signed [YW-1:0]  SQUAT_C  = YW'(SQUAT_Y);
  localparam logic signed [XCW-1:0] MIN_C    = XCW'(MIN_X);
  localparam logic signed [XCW-1:0] MAX_C    = XCW'(MAX_X);
  localparam logic signed [XCW-1:0] STEP_C   = XCW'(STEP_X);
  localparam logic signed [XCW-1:0] KB_C     = XCW'(KB_STEP);
  localparam logic signed [XW-1:0]  MIN_XW   = XW'(MIN_X);
  localparam logic signed [XW-1:0]  MAX_XW   = XW'(MAX_X);

  typedef enum logic [1:0] {V_GROUND, V_SQUAT, V_AIR} v_state_t;
  typedef enum logic {H_FREE, H_KNOCK} h_state_t;

  v_state_t              v_reg, v_next;
  h_state_t              h_reg, h_next;
  logic [JW-1:0]         j_reg, j_next;
  logic [KW-1:0]         kb_reg, kb_next;
  logic                  dir_reg, dir_next;
  logic signed [XW-1:0]  x_reg, x_next;
  logic signed [YW-1:0]  y_reg, y_next;
  logic                  facing_reg, facing_next;
  logic                  blocked_reg, blocked_next;

  logic                  guard;
  logic signed [CW-1:0]  j_ext, arc_raw;
  logic                  arc_pos;
  logic signed [YW-1:0]  y_air;
  logic signed [XCW-1:0] x_move;

  assign guard = defend && (v_reg != V_AIR) && (h_reg != H_KNOCK);

  // Arc height is computed wide so the square cannot wrap before the max(0, .).
  assign j_ext   = CW'(j_reg);
  assign arc_raw = V0_C * j_ext - (G_C * j_ext * j_ext) / TWO_C;
  assign arc_pos = !arc_raw[CW-1] && (|arc_raw[CW-2:0]);
  assign y_air   = arc_pos ? (GROUND_C + arc_raw[YW-1:0]) : GROUND_C;

  always_comb begin
    v_next       = v_reg;
    j_next       = j_reg;
    y_next       = y_reg;
    h_next       = h_reg;
    kb_next      = kb_reg;
    dir_next     = dir_reg;
    x_next       = x_reg;
    facing_next  = facing_reg;
    blocked_next = blocked_reg;
    x_move       = XCW'(x_reg);

    if (tick) begin
      case (v_reg)
        V_AIR: begin
          y_next = y_air;
          if (j_reg == JW'(MAX_J)) begin
            v_next = V_GROUND;
            j_next = '0;
          end else begin
            j_next = j_reg + JW'(1);
          end
        end
        default: begin
          y_next = squat ? SQUAT_C : GROUND_C;
          if (jump) begin
            v_next = V_AIR;
            j_next = '0;
          end else begin
            v_next = squat ? V_SQUAT : V_GROUND;
          end
        end
      endcase

      blocked_next = hit && guard;

      // An unguarded hit (re)arms the knockback; the moves begin on the next tick.
      if (hit && !guard) begin
        h_next   = H_KNOCK;
        kb_next  = KW'(KB_LEN);
        dir_next = hit_dir;
      end else if (h_reg == H_KNOCK) begin
        x_move = dir_reg ? (x_move + KB_C) : (x_move - KB_C);
        if (kb_reg <= KW'(1)) begin
          h_next  = H_FREE;
          kb_next = '0;
        end else begin
          kb_next = kb_reg - KW'(1);
        end
      end else if (!guard) begin
        if (right) begin
          x_move      = x_move + STEP_C;
          facing_next = 1'b1;
        end else if (left) begin
          x_move      = x_move - STEP_C;
          facing_next = 1'b0;
        end
      end

      if (x_move < MIN_C) begin
        x_next = MIN_XW;
      end else if (x_move > MAX_C) begin
        x_next = MAX_XW;
      end else begin
        x_next = x_move[XW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg       <= V_GROUND;
      h_reg       <= H_FREE;
      j_reg       <= '0;
      kb_reg      <= '0;
      dir_reg     <= 1'b0;
      x_reg       <= XW'(START_X);
      y_reg       <= GROUND_C;
      facing_reg  <= FACE_INIT;
      blocked_reg <= 1'b0;
    end else begin
      v_reg       <= v_next;
      h_reg       <= h_next;
      j_reg       <= j_next;
      kb_reg      <= kb_next;
      dir_reg     <= dir_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      facing_reg  <= facing_next;
      blocked_reg <= blocked_next;
    end
  end

  assign x       = x_reg;
  assign y       = y_reg;
  assign facing  = facing_reg;
  assign isJ     = (v_reg == V_AIR);
  assign isQ     = (v_reg == V_SQUAT);
  assign isK     = (h_reg == H_KNOCK);
  assign isD     = guard;
  assign blocked = blocked_reg;

endmodule

// File: tb/tb_fighter_motion.sv
// Scoreboard bench for fighter_motion: the driver pushes model predictions per
// tick/reset, an independent monitor pops and compares one clock later.
module tb_fighter_motion;

  localparam int GY = -200, SQ = -230, STEP = 4, V0 = 20, G = 4, MAX_J = 10;
  localparam int KB = 8, KB_LEN = 6, MINX = 40, MAXX = 600, STARTX = 560;
  localparam bit FACE0 = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, tick = 1'b0;
  logic right = 1'b0, left = 1'b0, jump = 1'b0, squat = 1'b0;
  logic defend = 1'b0, hit = 1'b0, hit_dir = 1'b0;
  logic signed [10:0] x;
  logic signed [9:0]  y;
  logic facing, isJ, isQ, isD, isK, blocked;

  fighter_motion dut (
    .clk(clk), .rst(rst), .tick(tick), .right(right), .left(left),
    .jump(jump), .squat(squat), .defend(defend), .hit(hit), .hit_dir(hit_dir),
    .x(x), .y(y), .facing(facing), .isJ(isJ), .isQ(isQ), .isD(isD),
    .isK(isK), .blocked(blocked)
  );

  typedef struct {
    int x; int y; bit face; bit isj; bit isq; bit isk; bit blk;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   checks = 0, errors = 0, txn = 0;

  // Behavioural model: fighter described by position, jump time and knock time left.
  int m_x, m_y, m_j, m_kb;
  bit m_air, m_sq, m_face, m_dir, m_blk;

  function automatic int arc_height(int t);
    int h;
    h = V0 * t - (G * t * t) / 2;
    return (h < 0) ? 0 : h;
  endfunction

  function automatic void model_reset();
    m_x = STARTX; m_y = GY; m_j = 0; m_kb = 0;
    m_air = 0; m_sq = 0; m_face = FACE0; m_dir = 0; m_blk = 0;
  endfunction

  function automatic void model_tick();
    bit guarding;
    guarding = defend && !m_air && (m_kb == 0);
    if (m_air) begin
      m_y = GY + arc_height(m_j);
      if (m_j == MAX_J) begin m_air = 0; m_j = 0; end
      else m_j = m_j + 1;
    end else begin
      m_y = squat ? SQ : GY;
      if (jump) begin m_air = 1; m_j = 0; m_sq = 0; end
      else m_sq = squat;
    end
    m_blk = hit && guarding;
    if (hit && !guarding) begin
      m_kb = KB_LEN; m_dir = hit_dir;
    end else if (m_kb > 0) begin
      m_x = m_dir ? m_x + KB : m_x - KB;
      m_kb = m_kb - 1;
    end else if (!guarding) begin
      if (right) begin m_x = m_x + STEP; m_face = 1; end
      else if (left) begin m_x = m_x - STEP; m_face = 0; end
    end
    if (m_x < MINX) m_x = MINX;
    if (m_x > MAXX) m_x = MAXX;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.x = m_x; e.y = m_y; e.face = m_face; e.isj = m_air;
    e.isq = m_sq; e.isk = (m_kb > 0); e.blk = m_blk;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    check({tag, "_x"}, int'(x), e.x);
    check({tag, "_y"}, int'(y), e.y);
    check({tag, "_facing"}, int'(facing), int'(e.face));
    check({tag, "_isJ"}, int'(isJ), int'(e.isj));
    check({tag, "_isQ"}, int'(isQ), int'(e.isq));
    check({tag, "_isK"}, int'(isK), int'(e.isk));
    check({tag, "_blocked"}, int'(blocked), int'(e.blk));
  endtask

  // Monitor: an update is presented the clock after any rst or tick edge.
  initial begin
    bit ev;
    forever begin
      @(posedge clk);
      ev = rst || tick;
      @(negedge clk);
      if (ev) begin
        if (q.size() == 0) begin
          check("scoreboard_empty", 1, 0);
        end else begin
          cur = q.pop_front();
          have_cur = 1'b1;
          txn++;
          $display("txn %0d: x=%0d y=%0d facing=%0b isJ=%0b isQ=%0b isK=%0b blocked=%0b",
                   txn, x, y, facing, isJ, isQ, isK, blocked);
          cmp_all("upd", cur);
        end
      end else if (have_cur) begin
        cmp_all("hold", cur);
      end
      if (have_cur)
        check("isD", int'(isD), int'(defend && !cur.isj && !cur.isk));
    end
  end

  task automatic step_full(input bit rs, input bit t, input bit r, input bit l,
                           input bit j, input bit s, input bit d, input bit h,
                           input bit hd);
    rst = rs; tick = t; right = r; left = l; jump = j; squat = s;
    defend = d; hit = h; hit_dir = hd;
    if (rs) begin model_reset(); q.push_back(snap()); end
    else if (t) begin model_tick(); q.push_back(snap()); end
    @(posedge clk);
    #2;
  endtask

  task automatic tk(input bit r, input bit l, input bit j, input bit s,
                    input bit d, input bit h, input bit hd);
    step_full(1'b0, 1'b1, r, l, j, s, d, h, hd);
  endtask

  initial begin
    int x0;
    step_full(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step_full(1, 1, 1, 1, 1, 1, 1, 1, 1);
    check("reset_x", int'(x), STARTX);
    check("reset_y", int'(y), GY);

    for (int i = 0; i < 20; i++) tk(1, 0, 0, 0, 0, 0, 0);
    check("walk_right_clamp", int'(x), MAXX);
    check("walk_right_facing", int'(facing), 1);
    for (int i = 0; i < 200; i++) tk(0, 1, 0, 0, 0, 0, 0);
    check("walk_left_clamp", int'(x), MINX);
    check("walk_left_facing", int'(facing), 0);

    tk(0, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 11; i++) begin
      tk(0, 0, (i == 4), (i == 5), 0, 0, 0);
      if (i == 6) check("jump_peak", int'(y), -150);
    end
    check("jump_land_y", int'(y), GY);
    check("jump_land_isJ", int'(isJ), 0);

    for (int i = 0; i < 3; i++) tk(0, 0, 0, 1, 0, 0, 0);
    check("squat_y", int'(y), SQ);
    tk(0, 0, 1, 1, 0, 0, 0);
    check("jump_from_squat_isQ", int'(isQ), 0);
    for (int i = 0; i < 12; i++) tk(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 65; i++) tk(1, 0, 0, 0, 0, 0, 0);
    check("walk_to_300", int'(x), 300);
    tk(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) tk(1, 0, 0, 0, 0, 0, 0);
    check("knock_dist", int'(x), 252);
    check("knock_done", int'(isK), 0);
    tk(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) tk(0, 0, 0, 0, 0, 0, 0);
    tk(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) tk(0, 0, 0, 0, 0, 0, 0);

    x0 = int'(x);
    tk(0, 0, 0, 0, 1, 1, 1);
    check("block_pulse", int'(blocked), 1);
    check("block_x", int'(x), x0);
    tk(0, 0, 0, 0, 1, 0, 0);
    check("block_clear", int'(blocked), 0);
    tk(0, 0, 1, 0, 0, 0, 0);
    tk(0, 0, 0, 0, 1, 1, 0);
    check("air_hit_knock", int'(isK), 1);
    for (int i = 0; i < 50; i++) step_full(0, 0, 1, 1, 1, 1, 1, 1, 1);
    tk(0, 0, 0, 0, 0, 0, 0);
    step_full(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_abort_x", int'(x), STARTX);
    check("rst_abort_isJ", int'(isJ), 0);
    check("rst_abort_isK", int'(isK), 0);

    for (int i = 0; i < 2500; i++) begin
      step_full(($urandom_range(299) == 0), ($urandom_range(3) != 0),
                $urandom_range(1), $urandom_range(1), ($urandom_range(5) == 0),
                ($urandom_range(2) == 0), ($urandom_range(2) == 0),
                ($urandom_range(7) == 0), $urandom_range(1));
    end
    for (int i = 0; i < 3; i++) step_full(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
